// File: rtl/cond_flag_unit.sv
// Condition-flag register plus condition evaluator answering branch/predication queries.
// One-cycle response without hazard; queries stall while a flag write is pending; saturating statistics.
module cond_flag_unit #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [3:0]       flags_in,
  input  logic             flag_wr_pend,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       flags_q,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] cond_q;
  logic [3:0] eff_flags;
  logic       rsp_hs;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Flags: [3]=N [2]=Z [1]=C [0]=V
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = c & !z;
      4'd9:    r = !c | z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z & (n == v);
      4'd13:   r = z | (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Same-cycle flag writes are visible to the evaluation through this bypass.
  assign eff_flags = flag_we ? flags_in : flags_q;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cond_q    <= 4'd0;
      rsp_tag   <= '0;
      rsp_taken <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cond_q  <= req_cond;
            rsp_tag <= req_tag;
            if (!flag_wr_pend) begin
              rsp_taken <= eval_cond(req_cond, eff_flags);
              state     <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!flag_wr_pend) begin
            rsp_taken <= eval_cond(cond_q, eff_flags);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'd0;
    end else if (flag_we) begin
      flags_q <= flags_in;
    end
  end

  // Clear wins over a coincident handshake increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (clr_cnt) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (rsp_hs) begin
      if (rsp_taken) begin
        if (taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + 1'b1;
      end else begin
        if (ntaken_cnt != CNT_MAX) ntaken_cnt <= ntaken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed corner cases, full condition table, random traffic.
module tb_cond_flag_unit;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flag_we;
  logic [3:0]       flags_in;
  logic             flag_wr_pend;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cond;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_taken;
  logic [TAG_W-1:0] rsp_tag;
  logic [3:0]       flags_q;
  logic             clr_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] ntaken_cnt;

  cond_flag_unit #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flags_in(flags_in),
    .flag_wr_pend(flag_wr_pend), .req_valid(req_valid), .req_ready(req_ready),
    .req_cond(req_cond), .req_tag(req_tag), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_taken(rsp_taken), .rsp_tag(rsp_tag),
    .flags_q(flags_q), .clr_cnt(clr_cnt), .taken_cnt(taken_cnt),
    .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mtaken, mntaken;
  logic [3:0] mflags;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;
  vec_t tbl[256];

  // Pairs of codes share a base condition; odd codes are the complement.
  function automatic logic cond_ref(input int c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 14) return 1'b1;
    if (c == 15) return 1'b0;
    case (c / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (c % 2 == 1) ? !base : base;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_hs(input bit t);
    if (t) mtaken  = (mtaken  < CMAX) ? mtaken + 1  : CMAX;
    else   mntaken = (mntaken < CMAX) ? mntaken + 1 : CMAX;
  endtask

  task automatic chk_cnts(input string name);
    chk({name, "_taken_cnt"}, int'(taken_cnt), mtaken);
    chk({name, "_ntaken_cnt"}, int'(ntaken_cnt), mntaken);
  endtask

  // No-hazard query, optionally with a coincident flag write, then an immediate handshake.
  task automatic do_query(input string name, input int c, input int tag, input bit we,
                          input logic [3:0] fl, input bit exp);
    flag_we = we; flags_in = fl;
    req_valid = 1'b1; req_cond = 4'(c); req_tag = TAG_W'(tag);
    if (we) mflags = fl;
    cyc();
    req_valid = 1'b0; flag_we = 1'b0;
    chk({name, "_vld"}, int'(rsp_valid), 1);
    chk({name, "_taken"}, int'(rsp_taken), int'(exp));
    chk({name, "_tag"}, int'(rsp_tag), tag);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    model_hs(exp);
    chk({name, "_idle"}, int'(rsp_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] ef, fl;
    bit p, we, e;
    int c, tag, k, cnt0;

    // Sweep table, filled up front from the reference model.
    for (int f = 0; f < 16; f++)
      for (int cc = 0; cc < 16; cc++) begin
        tbl[f*16+cc].flags = 4'(f);
        tbl[f*16+cc].cond  = 4'(cc);
        tbl[f*16+cc].exp   = cond_ref(cc, 4'(f));
      end

    rst_n = 1'b0; flag_we = 0; flags_in = 0; flag_wr_pend = 0;
    req_valid = 0; req_cond = 0; req_tag = 0; rsp_ready = 0; clr_cnt = 0;
    mtaken = 0; mntaken = 0; mflags = 0;
    cyc(); cyc();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_taken", int'(rsp_taken), 0);
    chk("rst_rsp_tag", int'(rsp_tag), 0);
    chk("rst_flags_q", int'(flags_q), 0);
    chk_cnts("rst");
    rst_n = 1'b1;
    cyc();

    // Bypass: CMP 5 vs 3 gives C=1 only; GT taken, then EQ not taken.
    do_query("byp_gt", 12, 5, 1'b1, 4'b0010, 1'b1);
    chk("byp_flags_q", int'(flags_q), 2);
    chk_cnts("byp_gt");
    do_query("byp_eq", 0, 6, 1'b0, 4'b0000, 1'b0);
    chk_cnts("byp_eq");

    // Hazard stall: three pending cycles, then drop with a Z=1 write.
    flag_wr_pend = 1'b1; req_valid = 1'b1; req_cond = 4'd0; req_tag = 4'd9;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("haz_stall_vld", int'(rsp_valid), 0);
      chk("haz_stall_rdy", int'(req_ready), 0);
      cyc();
    end
    chk("haz_stall_vld", int'(rsp_valid), 0);
    flag_wr_pend = 1'b0; flag_we = 1'b1; flags_in = 4'b0100; mflags = 4'b0100;
    cyc();
    flag_we = 1'b0;
    chk("haz_vld", int'(rsp_valid), 1);
    chk("haz_taken", int'(rsp_taken), 1);
    chk("haz_tag", int'(rsp_tag), 9);
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    model_hs(1'b1);
    chk_cnts("haz");

    // Backpressure: response held five cycles while req_valid toggles.
    req_valid = 1'b1; req_cond = 4'd14; req_tag = 4'd3;
    cyc();
    cnt0 = int'(taken_cnt);
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0]; req_tag = 4'd11; req_cond = 4'd15;
      cyc();
      chk("bp_vld", int'(rsp_valid), 1);
      chk("bp_taken", int'(rsp_taken), 1);
      chk("bp_tag", int'(rsp_tag), 3);
      chk("bp_rdy", int'(req_ready), 0);
      chk("bp_cnt_hold", int'(taken_cnt), cnt0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    model_hs(1'b1);
    chk("bp_released", int'(rsp_valid), 0);
    chk_cnts("bp");
    cyc();
    chk("bp_no_second", int'(rsp_valid), 0);

    // Full condition sweep through the bypass path.
    for (int i = 0; i < 256; i++) begin
      do_query("sweep", int'(tbl[i].cond), i % 16, 1'b1, tbl[i].flags, tbl[i].exp);
      chk("sweep_flags_q", int'(flags_q), int'(tbl[i].flags));
    end
    chk_cnts("sweep");

    // Random traffic with hazards, in-flight writes and response stalls.
    for (int i = 0; i < 300; i++) begin
      c = $urandom_range(0, 15); tag = $urandom_range(0, 15);
      p = ($urandom_range(0, 2) == 0); we = 1'($urandom_range(0, 1)); fl = 4'($urandom_range(0, 15));
      flag_we = we; flags_in = fl; flag_wr_pend = p;
      req_valid = 1'b1; req_cond = 4'(c); req_tag = 4'(tag);
      ef = we ? fl : mflags;
      if (we) mflags = fl;
      cyc();
      req_valid = 1'b0; flag_we = 1'b0;
      if (p) begin
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
          we = 1'($urandom_range(0, 1)); fl = 4'($urandom_range(0, 15));
          flag_we = we; flags_in = fl;
          if (we) mflags = fl;
          chk("rnd_wait_vld", int'(rsp_valid), 0);
          cyc();
        end
        chk("rnd_wait_vld", int'(rsp_valid), 0);
        we = 1'($urandom_range(0, 1)); fl = 4'($urandom_range(0, 15));
        flag_wr_pend = 1'b0; flag_we = we; flags_in = fl;
        ef = we ? fl : mflags;
        if (we) mflags = fl;
        cyc();
        flag_we = 1'b0;
      end
      e = cond_ref(c, ef);
      chk("rnd_vld", int'(rsp_valid), 1);
      chk("rnd_taken", int'(rsp_taken), int'(e));
      chk("rnd_tag", int'(rsp_tag), tag);
      chk("rnd_flags_q", int'(flags_q), int'(mflags));
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        cyc();
        chk("rnd_hold_taken", int'(rsp_taken), int'(e));
        chk("rnd_hold_tag", int'(rsp_tag), tag);
      end
      rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
      model_hs(e);
      chk_cnts("rnd");
    end

    // Saturation then clear coincident with a handshake.
    for (int i = 0; i < 17; i++) do_query("sat", 14, i % 16, 1'b0, 4'b0000, 1'b1);
    chk("sat_taken_cnt", int'(taken_cnt), 15);
    req_valid = 1'b1; req_cond = 4'd14; req_tag = 4'd7;
    cyc();
    req_valid = 1'b0; rsp_ready = 1'b1; clr_cnt = 1'b1;
    cyc();
    rsp_ready = 1'b0; clr_cnt = 1'b0;
    mtaken = 0; mntaken = 0;
    chk("clr_taken_cnt", int'(taken_cnt), 0);
    chk_cnts("clr");

    // Asynchronous reset while a response is pending.
    req_valid = 1'b1; req_cond = 4'd14; req_tag = 4'd12;
    cyc();
    req_valid = 1'b0;
    chk("mid_pre_vld", int'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", int'(rsp_valid), 0);
    chk("mid_rst_rdy", int'(req_ready), 1);
    chk("mid_rst_flags", int'(flags_q), 0);
    mtaken = 0; mntaken = 0; mflags = 0;
    chk_cnts("mid_rst");
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_rst_vld", int'(rsp_valid), 0);
    chk("post_rst_rdy", int'(req_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Condition-flag register and condition evaluator for the execute stage; it is the consumer of the 4-bit flag vector produced by the compare/ALU blocks. It latches flag updates and answers condition queries from the branch/predication logic over a valid/ready handshake, returning taken or not-taken with a tag. It stalls a query while a flag-setting instruction is still in flight, and keeps saturating taken/not-taken statistics.

## Interface
Parameters:
- TAG_W, 4, width of the request/response tag
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flag_we  in  1  load flags_in into the flag register this cycle
- flags_in  in  4  [3]=N (sign), [2]=Z, [1]=C, [0]=V; same ordering as the ALU/CMP result flags
- flag_wr_pend  in  1  a flag-setting instruction is in execute and has not yet written
- req_valid  in  1  condition query valid
- req_ready  out  1  query accepted when req_valid && req_ready
- req_cond  in  4  condition code, encoding under Operation
- req_tag  in  TAG_W  opaque tag, returned unchanged with the response
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_taken  out  1  condition result
- rsp_tag  out  TAG_W  tag of the answered query
- flags_q  out  4  current flag register
- clr_cnt  in  1  synchronous clear of both counters
- taken_cnt  out  CNT_W  responses delivered with rsp_taken=1, saturating
- ntaken_cnt  out  CNT_W  responses delivered with rsp_taken=0, saturating

## Operation
- Flag register: flags_q loads flags_in on any cycle with flag_we=1, in every state.
- Effective flags F: flags_in when flag_we=1 this cycle, otherwise flags_q (write bypass).
- Condition encoding, evaluated on F:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On accept, cond and tag are captured. If flag_wr_pend=0, the result is evaluated on F that cycle, registered, and the FSM goes to RESP. If flag_wr_pend=1, it goes to WAIT.
  - WAIT: req_ready=0. In the first cycle with flag_wr_pend=0, the result is evaluated on F and the FSM goes to RESP. This covers a flag_we in that same cycle through the bypass. The FSM has no timeout.
  - RESP: rsp_valid=1. rsp_taken and rsp_tag stay stable until rsp_ready=1, then the FSM returns to IDLE. A new request is never accepted in the same cycle as a response handshake.
- Counters update on each response handshake. The counter selected by rsp_taken increments and holds at 2^CNT_W-1. clr_cnt=1 zeroes both counters and takes priority over a same-cycle increment.
- Reset, including reset mid-operation: state IDLE, any pending query dropped, no response emitted.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_taken=0, rsp_tag=0, flags_q=4'b0000, taken_cnt=0, ntaken_cnt=0.
- req_ready is decoded from the state register only, with no combinational path from req_valid.
- Latency with no hazard: accept at cycle T gives rsp_valid at T+1.
- Latency with a hazard: the first cycle with flag_wr_pend=0 at or after T+1 is C, and rsp_valid rises at C+1.
- Peak throughput: one query per 2 cycles (IDLE then RESP with rsp_ready=1).
- flags_q is visible one cycle after flag_we. A query evaluated in the flag_we cycle already sees the new flags.

## Test plan
- Reset and idle: assert rst_n=0 mid-RESP, then release -> rsp_valid=0, req_ready=1, flags_q=0, both counters 0.
- Bypass: flag_we=1 with flags_in=4'b0010 (CMP 5 vs 3) and a GT query (12) in the same cycle -> rsp_taken=1 next cycle. An EQ query (0) afterwards -> rsp_taken=0.
- Hazard stall: accept an EQ query with flag_wr_pend=1 for 3 cycles, then drop it together with flag_we=1 and flags_in=4'b0100 -> no response during the stall, rsp_taken=1 one cycle after the drop, tag preserved.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid -> rsp_taken and rsp_tag stable, req_ready=0, no second accept. The counter increments exactly once after release.
- Full condition sweep: for each of the 16 flag patterns, issue all 16 codes -> every result matches the table, including AL=1 and NV=0.
- Counter saturation and clear: with CNT_W=4, deliver 17 taken responses -> taken_cnt=15. clr_cnt coincident with a handshake -> taken_cnt=0.
